// File: rtl/decode_pipe_sb.sv
// Decode stage with registered ID/EX output, an 8-entry GPR file and a per-register pending-write scoreboard.
// Optional `DECODE_BYPASS_EN forwards the write-back value to a source whose last pending write is retiring.
module decode_pipe_sb #(
  parameter int DATA_W       = 16,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [2:0]        in_rd,
  input  logic              in_rd_we,
  input  logic              in_use_rs,
  input  logic              in_use_rt,
  input  logic              in_zext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm5,
  output logic [DATA_W-1:0] out_imm8,
  output logic [DATA_W-1:0] out_imm11,
  output logic [2:0]        out_rd,
  output logic              out_rd_we,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [DATA_W-1:0] gpr [8];
  logic [CNT_W-1:0]  cnt [8];

  logic [2:0]        rs, rt;
  logic              byp_rs, byp_rt;
  logic              hz_rs, hz_rt, hz_rd;
  logic              issue;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic [DATA_W-1:0] imm5, imm8, imm11;
  logic [7:0]        cnt_inc, cnt_dec;

  assign rs = in_instr[10:8];
  assign rt = in_instr[7:5];

`ifdef DECODE_BYPASS_EN
  assign byp_rs = wb_en && (wb_sel == rs) && (cnt[rs] == CNT_W'(1));
  assign byp_rt = wb_en && (wb_sel == rt) && (cnt[rt] == CNT_W'(1));
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif

  assign hz_rs = in_use_rs && (cnt[rs] != '0) && !byp_rs;
  assign hz_rt = in_use_rt && (cnt[rt] != '0) && !byp_rt;
  assign hz_rd = in_rd_we && (cnt[in_rd] == CNT_W'(MAX_INFLIGHT));

  assign in_ready = (!out_valid || out_ready) && !hz_rs && !hz_rt && !hz_rd && !flush;
  assign issue    = in_valid && in_ready;

  assign rs_data = byp_rs ? wb_data : gpr[rs];
  assign rt_data = byp_rt ? wb_data : gpr[rt];

  assign imm5  = in_zext ? {{(DATA_W-5){1'b0}}, in_instr[4:0]}
                         : {{(DATA_W-5){in_instr[4]}}, in_instr[4:0]};
  assign imm8  = in_zext ? {{(DATA_W-8){1'b0}}, in_instr[7:0]}
                         : {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
  assign imm11 = {{(DATA_W-11){in_instr[10]}}, in_instr[10:0]};

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int r = 0; r < 8; r++) begin
      cnt_inc[r] = issue && in_rd_we && (in_rd == 3'(r));
      cnt_dec[r] = wb_en && (wb_sel == 3'(r)) && (cnt[r] != '0);
    end
  end

  // Write-back lands even during flush; only the scoreboard is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 8; r++) gpr[r] <= '0;
    end else if (wb_en) begin
      gpr[wb_sel] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 8; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        if (flush)
          cnt[r] <= '0;
        else if (cnt_inc[r] && !cnt_dec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (cnt_dec[r] && !cnt_inc[r])
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err <= 1'b0;
    else if (wb_en && !flush && (cnt[wb_sel] == '0))
      err <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm5    <= '0;
      out_imm8    <= '0;
      out_imm11   <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
    end else begin
      out_valid <= !flush && (issue || (out_valid && !out_ready));
      if (issue) begin
        out_instr   <= in_instr;
        out_rs_data <= rs_data;
        out_rt_data <= rt_data;
        out_imm5    <= imm5;
        out_imm8    <= imm8;
        out_imm11   <= imm11;
        out_rd      <= in_rd;
        out_rd_we   <= in_rd_we;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe_sb.sv
// Directed bench for decode_pipe_sb: immediate-extension vector table plus hand-written hazard,
// back-pressure, flush and async-reset sequences.
module tb_decode_pipe_sb;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [15:0] in_instr;
  logic [2:0]  in_rd;
  logic        in_rd_we, in_use_rs, in_use_rt, in_zext;
  logic        out_valid, out_ready;
  logic [15:0] out_instr, out_rs_data, out_rt_data, out_imm5, out_imm8, out_imm11;
  logic [2:0]  out_rd;
  logic        out_rd_we;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [15:0] wb_data;
  logic        flush, err;

  int n_cmp = 0;
  int n_err = 0;

  decode_pipe_sb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt), .in_zext(in_zext),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm5(out_imm5),
    .out_imm8(out_imm8), .out_imm11(out_imm11), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] instr;
    logic        zext;
    logic [15:0] imm5;
    logic [15:0] imm8;
    logic [15:0] imm11;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    in_valid = 0; in_instr = 0; in_rd = 0; in_rd_we = 0; in_use_rs = 0; in_use_rt = 0;
    in_zext = 0; wb_en = 0; wb_sel = 0; wb_data = 0; flush = 0;
  endtask

  task automatic drive(input logic [15:0] instr, input logic [2:0] rd, input logic we,
                       input logic urs, input logic urt, input logic zext);
    in_valid = 1; in_instr = instr; in_rd = rd; in_rd_we = we;
    in_use_rs = urs; in_use_rt = urt; in_zext = zext;
  endtask

  task automatic issue_one(input string name, input logic [15:0] instr, input logic [2:0] rd,
                           input logic we, input logic urs, input logic urt, input logic zext);
    drive(instr, rd, we, urs, urt, zext);
    #1;
    check(name, 32'(in_ready), 32'd1);
    tick;
    in_valid = 0;
  endtask

  task automatic wb(input logic [2:0] sel, input logic [15:0] data);
    wb_en = 1; wb_sel = sel; wb_data = data;
    tick;
    wb_en = 0;
  endtask

  initial begin
    vecs[0] = '{16'h001F, 1'b0, 16'hFFFF, 16'h001F, 16'h001F};
    vecs[1] = '{16'h001F, 1'b1, 16'h001F, 16'h001F, 16'h001F};
    vecs[2] = '{16'h0400, 1'b0, 16'h0000, 16'h0000, 16'hFC00};
    vecs[3] = '{16'h00F0, 1'b0, 16'hFFF0, 16'hFFF0, 16'h00F0};
    vecs[4] = '{16'h00F0, 1'b1, 16'h0010, 16'h00F0, 16'h00F0};
    vecs[5] = '{16'h07FF, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[6] = '{16'hF80F, 1'b1, 16'h000F, 16'h000F, 16'h000F};
    vecs[7] = '{16'h03AA, 1'b0, 16'h000A, 16'hFFAA, 16'h03AA};

    clr_in;
    out_ready = 1;
    rst = 0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1;
    tick;

    // 1) write-back then read through rs
    issue_one("t1_writer_ready", 16'h0000, 3'd3, 1, 0, 0, 0);
    check("t1_writer_valid", 32'(out_valid), 32'd1);
    check("t1_writer_rd", 32'(out_rd), 32'd3);
    check("t1_writer_we", 32'(out_rd_we), 32'd1);
    wb(3'd3, 16'h1234);
    issue_one("t1_reader_ready", 16'h0300, 3'd0, 0, 1, 0, 0);
    check("t1_rs_data", 32'(out_rs_data), 32'h1234);
    check("t1_out_instr", 32'(out_instr), 32'h0300);
    check("t1_err", 32'(err), 32'd0);
    tick;

    // 2) RAW stall on rt
    issue_one("t2_writer_ready", 16'h0000, 3'd2, 1, 0, 0, 0);
    drive(16'h0040, 3'd0, 0, 0, 1, 0);
    #1;
    check("t2_stall_a", 32'(in_ready), 32'd0);
    tick;
    check("t2_stall_b", 32'(in_ready), 32'd0);
    tick;
    wb_en = 1; wb_sel = 3'd2; wb_data = 16'hBEEF;
    #1;
`ifdef DECODE_BYPASS_EN
    check("t2_bypass_ready", 32'(in_ready), 32'd1);
    tick;
    wb_en = 0; in_valid = 0;
`else
    check("t2_wb_cycle_ready", 32'(in_ready), 32'd0);
    tick;
    wb_en = 0;
    #1;
    check("t2_after_wb_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 0;
`endif
    check("t2_rt_data", 32'(out_rt_data), 32'hBEEF);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_err", 32'(err), 32'd0);
    tick;

    // 3) MAX_INFLIGHT writers to one register
    drive(16'h0000, 3'd5, 1, 0, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_writer%0d_ready", i), 32'(in_ready), 32'd1);
      tick;
    end
    check("t3_full_a", 32'(in_ready), 32'd0);
    tick;
    check("t3_full_b", 32'(in_ready), 32'd0);
    wb_en = 1; wb_sel = 3'd5; wb_data = 16'h5555;
    #1;
    check("t3_wb_cycle", 32'(in_ready), 32'd0);
    tick;
    wb_en = 0;
    #1;
    check("t3_after_wb", 32'(in_ready), 32'd1);
    tick;
    in_valid = 0;
    for (int i = 0; i < 3; i++) wb(3'd5, 16'h5555);
    check("t3_err", 32'(err), 32'd0);

    // 4) downstream back-pressure
    out_ready = 0;
    issue_one("t4_a_ready", 16'h5A5A, 3'd0, 0, 0, 0, 0);
    drive(16'h1357, 3'd0, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_hold%0d_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("t4_hold%0d_instr", i), 32'(out_instr), 32'h5A5A);
      check($sformatf("t4_hold%0d_valid", i), 32'(out_valid), 32'd1);
      tick;
    end
    out_ready = 1;
    #1;
    check("t4_release_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 0;
    check("t4_b_instr", 32'(out_instr), 32'h1357);
    check("t4_b_valid", 32'(out_valid), 32'd1);
    tick;

    // 5) flush with pending writes and coincident write-back
    issue_one("t5_w1_ready", 16'h0000, 3'd1, 1, 0, 0, 0);
    issue_one("t5_w2_ready", 16'h0000, 3'd1, 1, 0, 0, 0);
    flush = 1; wb_en = 1; wb_sel = 3'd1; wb_data = 16'h7777;
    #1;
    check("t5_flush_ready", 32'(in_ready), 32'd0);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    tick;
    flush = 0; wb_en = 0;
    check("t5_post_valid", 32'(out_valid), 32'd0);
    check("t5_post_err", 32'(err), 32'd0);
    issue_one("t5_cnt_cleared", 16'h0100, 3'd0, 0, 1, 0, 0);
    check("t5_gpr1", 32'(out_rs_data), 32'h7777);
    wb(3'd1, 16'h1111);
    check("t5_err_set", 32'(err), 32'd1);
    tick; tick; tick;
    check("t5_err_sticky", 32'(err), 32'd1);

    // 6) async reset in the middle of a stall
    issue_one("t6_writer_ready", 16'h0000, 3'd1, 1, 0, 0, 0);
    out_ready = 0;
    drive(16'h0100, 3'd0, 0, 1, 0, 0);
    #1;
    check("t6_stalled", 32'(in_ready), 32'd0);
    #2;
    rst = 0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_err", 32'(err), 32'd0);
    check("t6_rst_rd", 32'(out_rd), 32'd0);
    check("t6_rst_we", 32'(out_rd_we), 32'd0);
    #1;
    rst = 1;
    out_ready = 1;
    #1;
    check("t6_cnt_cleared", 32'(in_ready), 32'd1);
    tick;
    in_valid = 0;
    check("t6_gpr_cleared", 32'(out_rs_data), 32'h0000);
    check("t6_issue_valid", 32'(out_valid), 32'd1);
    tick;

    // 7) immediate extension table
    for (int i = 0; i < 8; i++) begin
      issue_one($sformatf("t7_v%0d_ready", i), vecs[i].instr, 3'd0, 0, 0, 0, vecs[i].zext);
      check($sformatf("t7_v%0d_instr", i), 32'(out_instr), 32'(vecs[i].instr));
      check($sformatf("t7_v%0d_imm5", i), 32'(out_imm5), 32'(vecs[i].imm5));
      check($sformatf("t7_v%0d_imm8", i), 32'(out_imm8), 32'(vecs[i].imm8));
      check($sformatf("t7_v%0d_imm11", i), 32'(out_imm11), 32'(vecs[i].imm11));
    end
    tick;
    check("end_idle_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
